// File: rtl/counter_arbiter.sv
// counter_arbiter: grants one shared N-bit up-counter to one of R requesters at a time.
// The counter runs from 0 to the winner's latched terminal count, then pulses done.
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   asynchronous active-low reset
//   req    in   [R]   level request per requester
//   limit  in   [R*N] terminal count per requester, requester i at [i*N +: N]
//   grant  out  [R]   one-hot counter owner, zero when no owner
//   q      out  [N]   shared counter value
//   done   out  [R]   one-cycle completion pulse to the finishing requester
//   busy   out        high whenever the arbiter is not idle
// Build option: COUNTER_ARBITER_ROUND_ROBIN_EN selects round-robin arbitration;
// without it the lowest requesting index always wins.
module counter_arbiter #(
  parameter int N = 4,
  parameter int R = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [R-1:0]   req,
  input  logic [R*N-1:0] limit,
  output logic [R-1:0]   grant,
  output logic [N-1:0]   q,
  output logic [R-1:0]   done,
  output logic           busy
);
  localparam int W = $clog2(R);
  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;
  state_t state, state_n;
  logic [N-1:0] q_n, lim_r, lim_n;
  logic [R-1:0] grant_n, done_n;
  logic [W-1:0] w, w_n, ptr;
  int win;
`ifdef COUNTER_ARBITER_ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) ptr <= '0;
    else if (state == IDLE && |req) ptr <= W'((win + 1) % R);
`else
  assign ptr = '0;
`endif
  // Scan downward from the farthest slot so the requester closest to ptr is chosen last.
  always_comb begin
    win = 0;
    for (int k = R - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % R]) win = (int'(ptr) + k) % R;
  end
  always_comb begin
    state_n = state;
    q_n = q;
    grant_n = '0;
    done_n = '0;
    lim_n = lim_r;
    w_n = w;
    case (state)
      IDLE: begin
        q_n = '0;
        if (|req) begin
          state_n = COUNT;
          w_n = W'(win);
          lim_n = limit[win*N +: N];
          grant_n[win] = 1'b1;
        end
      end
      // Abandon is tested first so it beats a terminal count on the same edge.
      COUNT:
        if (!req[w]) begin
          state_n = IDLE;
          q_n = '0;
        end else if (q == lim_r) begin
          state_n = DONE;
          done_n[w] = 1'b1;
        end else begin
          q_n = q + 1'b1;
          grant_n = grant;
        end
      default: begin
        state_n = IDLE;
        q_n = '0;
      end
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      q <= '0;
      grant <= '0;
      done <= '0;
      lim_r <= '0;
      w <= '0;
    end else begin
      state <= state_n;
      q <= q_n;
      grant <= grant_n;
      done <= done_n;
      lim_r <= lim_n;
      w <= w_n;
    end
  assign busy = state != IDLE;
endmodule

// File: tb/tb_counter_arbiter.sv
// tb_counter_arbiter: scoreboard bench for counter_arbiter with a transaction-level model.
module tb_counter_arbiter;
  localparam int N = 4;
  localparam int R = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [R-1:0] req = '0;
  logic [R*N-1:0] limit = '0;
  logic [R-1:0] grant, done;
  logic [N-1:0] q;
  logic busy;
  int checks = 0;
  int fails = 0;
  int cyc = 0;
  int ptr_m = 0;
  bit run = 1'b0;
  typedef struct {
    int cyc;
    logic [R-1:0] g;
    logic [R-1:0] d;
    logic [N-1:0] q;
  } ev_t;
  ev_t exp_q[$];

  counter_arbiter #(.N(N), .R(R)) dut (
    .clk(clk), .reset(reset), .req(req), .limit(limit),
    .grant(grant), .q(q), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, pending=%0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void push(input int c, input logic [R-1:0] g, input logic [R-1:0] d,
                               input logic [N-1:0] qv);
    ev_t e;
    e.cyc = c;
    e.g = g;
    e.d = d;
    e.q = qv;
    exp_q.push_back(e);
  endfunction

  function automatic int pick(input logic [R-1:0] rq);
    int p;
`ifdef COUNTER_ARBITER_ROUND_ROBIN_EN
    p = ptr_m;
`else
    p = 0;
`endif
    for (int k = 0; k < R; k++)
      if (rq[(p + k) % R]) return (p + k) % R;
    return -1;
  endfunction

  // Called in an idle cycle; the arbitration edge is the next rising edge.
  // ab_q: drop the winner's request during the cycle showing that count (-1: never).
  // chg_q/chg_v: rewrite the winner's limit input during the cycle showing that count.
  task automatic issue(input logic [R-1:0] rq, input int ab_q, input bit keep,
                       input int chg_q, input int chg_v);
    int w, lim, c0;
    logic [R-1:0] oh;
    w = pick(rq);
    lim = int'(limit[w*N +: N]);
    oh = '0;
    oh[w] = 1'b1;
    ptr_m = (w + 1) % R;
    c0 = cyc;
    for (int k = 0; k <= lim && (ab_q < 0 || k <= ab_q); k++) push(c0 + 1 + k, oh, '0, N'(k));
    if (ab_q < 0 || ab_q > lim) push(c0 + 2 + lim, '0, oh, N'(lim));
    req = rq;
    tick();
    for (int k = 0; k <= lim; k++) begin
      if (k == chg_q) limit[w*N +: N] = N'(chg_v);
      if (k == ab_q) begin
        req[w] = 1'b0;
        tick();
        break;
      end
      tick();
      if (k == lim) begin
        if (!keep) req[w] = 1'b0;
        tick();
      end
    end
    if (!keep) req = '0;
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (run) begin
      if (grant != '0 || done != '0) begin
        checks++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL event: unexpected cyc=%0d grant=%b done=%b q=%0d", cyc, grant, done, q);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.g !== grant || e.d !== done || e.q !== q) begin
            fails++;
            $display("FAIL event: got cyc=%0d grant=%b done=%b q=%0d, expected cyc=%0d grant=%b done=%b q=%0d",
                     cyc, grant, done, q, e.cyc, e.g, e.d, e.q);
          end
        end
      end
      checks++;
      if (busy !== (grant != '0 || done != '0) || (grant == '0 && done == '0 && q !== '0)) begin
        fails++;
        $display("FAIL idle: cyc=%0d busy=%b grant=%b done=%b q=%0d", cyc, busy, grant, done, q);
      end
    end
  end

  initial begin
    int c0, ab;
    logic [R-1:0] rq;
    bit kp;
    #1 reset = 1'b0;
    #1 run = 1'b1;
    #1;
    check("reset q", int'(q), 0);
    check("reset grant", int'(grant), 0);
    check("reset done", int'(done), 0);
    check("reset busy", int'(busy), 0);
    tick();
    tick();
    reset = 1'b1;
    limit = {4'd1, 4'd1, 4'd1, 4'd1};
    repeat (5) issue(4'b1111, -1, 1'b1, -1, 0);
    req = '0;
    limit = '0;
    limit[3:0] = 4'd3;
    issue(4'b0001, -1, 1'b0, -1, 0);
    check("single idle q", int'(q), 0);
    limit[11:8] = 4'd0;
    issue(4'b0100, -1, 1'b0, -1, 0);
    limit[11:8] = 4'd15;
    issue(4'b0100, -1, 1'b0, -1, 0);
    limit[7:4] = 4'd7;
    issue(4'b0010, 2, 1'b0, -1, 0);
    check("abandon grant", int'(grant), 0);
    check("abandon q", int'(q), 0);
    limit[7:4] = 4'd4;
    issue(4'b0010, 4, 1'b0, -1, 0);
    limit[3:0] = 4'd3;
    issue(4'b0001, -1, 1'b0, 1, 12);
    limit[3:0] = 4'd9;
    req = 4'b0001;
    c0 = cyc;
    for (int k = 0; k < 5; k++) push(c0 + 1 + k, 4'b0001, '0, N'(k));
    repeat (6) tick();
    check("pre-reset q", int'(q), 5);
    #2 reset = 1'b0;
    #1;
    check("mid reset q", int'(q), 0);
    check("mid reset grant", int'(grant), 0);
    check("mid reset busy", int'(busy), 0);
    ptr_m = 0;
    tick();
    tick();
    reset = 1'b1;
    limit[3:0] = 4'd2;
    issue(4'b0001, -1, 1'b0, -1, 0);
    repeat (40) begin
      rq = R'($urandom_range(1, (1 << R) - 1));
      limit = (R*N)'($urandom);
      ab = -1;
      if ($urandom_range(0, 3) == 0) ab = int'($urandom_range(0, 15));
      kp = 1'($urandom_range(0, 1));
      issue(rq, ab, kp, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
      if (!kp) repeat ($urandom_range(0, 2)) tick();
    end
    req = '0;
    repeat (4) tick();
    check("scoreboard drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/counter_arbiter.md
# counter_arbiter

Shares one N-bit up-counter among R requesters that each need a timed interval of programmable length. Grants the counter to one requester at a time, runs it from 0 to that requester's latched terminal count and signals completion with a one-cycle done pulse. Sits between requesting control blocks and the shared counter datapath, and sequences the counter's reset and enable.

## Interface
- N, default 4: counter width in bits.
- R, default 4: number of requesters, R ≥ 2.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  R  request per requester; level, held high until done or abandoned.
- limit  in  R*N  terminal count per requester; requester i uses bits [i*N +: N].
- grant  out  R  one-hot owner of the counter; all zero when no owner.
- q  out  N  shared counter value.
- done  out  R  one-cycle completion pulse to the finishing requester.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- States: IDLE, COUNT, DONE.
- IDLE: q=0, grant=0, done=0. If any req bit is high, select a winner w (see Configuration). Latch limit[w] into lim_r. Next state is COUNT with grant=onehot(w) and q=0.
- COUNT: at each edge, if req[w]=0 (abandon), go to IDLE: grant=0, q=0, no done pulse.
- COUNT, otherwise: if q==lim_r, go to DONE. Else q=q+1.
- DONE: grant=0, done[w]=1, q holds the final value (lim_r). Next state is always IDLE, where q returns to 0 and done returns to 0.
- Width and arithmetic: q is N bits unsigned and never wraps. Termination is by equality with lim_r, so the maximum lim_r is 2^N-1.
- limit changes during COUNT are ignored; only lim_r is used.
- lim_r=0: one COUNT cycle with q=0, then DONE.
- Priority pointer ptr, round-robin build only: after granting w, ptr=(w+1) mod R. The search starts at ptr and wraps from R-1 to 0.
- A requester that keeps req high after its done pulse re-enters arbitration in the following IDLE cycle like any other requester.
- Abandon and terminal count on the same edge: abandon wins. The result is IDLE, no done pulse.

## Timing
- Reset (reset=0) acts immediately, regardless of the clock or the current state, including mid-COUNT:
  - state=IDLE, q=0, grant=0, done=0, busy=0, ptr=0, lim_r=0.
  - Operation resumes on the first rising edge after reset=1.
- Arbitration latency: req is sampled at an edge in IDLE; grant is visible right after that edge.
- grant is high for exactly lim_r+1 cycles, with q = 0, 1, …, lim_r.
- done rises on the edge after the cycle where q==lim_r is observed, and lasts exactly 1 cycle.
- Back-to-back grants: the minimum gap is 2 cycles (DONE plus IDLE) between the last grant cycle of one requester and the first of the next.
- Abandon: grant drops on the first edge that samples req[w]=0.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- COUNTER_ARBITER_ROUND_ROBIN_EN defined: round-robin arbitration using ptr as described above.
- Not defined: fixed priority, where the lowest index with req high wins. ptr is not implemented and is treated as 0.
- All other behaviour is identical in both builds.

## Test plan
Parameters for all scenarios: N=4, R=4.
- Reset mid-count:
  - Stimulus: req=0001, limit0=9, assert reset=0 while q=5 and between clock edges.
  - Required: q=0, grant=0000, busy=0 immediately. After reset=1, a fresh grant=0001 follows with q starting at 0.
- Single request:
  - Stimulus: req=0001, limit0=3.
  - Required: grant=0001 with q=0,1,2,3 over 4 cycles. Then one cycle with grant=0000, done=0001, q=3. Then IDLE with q=0.
- Contention:
  - Stimulus: req=1111 held, all limits=1.
  - Required, macro defined: grant order 0001, 0010, 0100, 1000, 0001.
  - Required, macro undefined: grant=0001 every interval.
- Zero and maximum limit:
  - Stimulus: limit2=0, then limit2=15, requester 2 only.
  - Required for 0: one grant cycle with q=0, then done=0100.
  - Required for 15: q reaches 15 with no wrap, then done=0100 with q=15.
- Abandon:
  - Stimulus: req=0010, limit1=7, drop req1 while q=2.
  - Required: on the next edge grant=0000 and q=0. done stays 0000 throughout.
- Simultaneous abandon and terminal:
  - Stimulus: drop req on the cycle where q==lim_r.
  - Required: IDLE, no done pulse.
- Limit change during COUNT:
  - Stimulus: limit0 changed from 3 to 12 while q=1.
  - Required: count still ends at q=3.
